// File: rtl/wfg_seq_ctrl_if.sv
// rtl/wfg_seq_ctrl_if.sv - segment table write port of the waveform sequencer
// The register side drives entries in; the sequencer answers with a dropped-write pulse.
interface wfg_seq_ctrl_if #(
  parameter int NUM_SEG = 4
);
  localparam int SEG_W = $clog2(NUM_SEG);

  logic             wr_en_i;
  logic [SEG_W-1:0] wr_addr_i;
  logic [7:0]       wr_sync_cnt_i;
  logic [15:0]      wr_subcycle_cnt_i;
  logic [7:0]       wr_repeat_i;
  logic             wr_err_o;

  modport master (
    output wr_en_i,
    output wr_addr_i,
    output wr_sync_cnt_i,
    output wr_subcycle_cnt_i,
    output wr_repeat_i,
    input  wr_err_o
  );

  modport slave (
    input  wr_en_i,
    input  wr_addr_i,
    input  wr_sync_cnt_i,
    input  wr_subcycle_cnt_i,
    input  wr_repeat_i,
    output wr_err_o
  );
endinterface

// File: rtl/wfg_seq_ctrl.sv
// rtl/wfg_seq_ctrl.sv - segment sequencer driving the waveform pattern core
// Steps a small (sync, subcycle, repeat) table on core sync pulses, then loops or stops.
module wfg_seq_ctrl #(
  parameter int NUM_SEG = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  wfg_seq_ctrl_if.slave              wr_if,
  input  logic [$clog2(NUM_SEG)-1:0] cfg_last_seg_i,
  input  logic                       cfg_loop_i,
  input  logic                       start_i,
  input  logic                       stop_i,
  input  logic                       wfg_pat_sync_i,
  output logic                       core_en_o,
  output logic [7:0]                 core_sync_count_o,
  output logic [15:0]                core_subcycle_count_o,
  output logic [$clog2(NUM_SEG)-1:0] seg_idx_o,
  output logic                       busy_o,
  output logic                       done_o
);
  localparam int SEG_W = $clog2(NUM_SEG);
  localparam logic [SEG_W-1:0] SEG_ZERO = '0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       sync_tab_q [NUM_SEG];
  logic [15:0]      sub_tab_q  [NUM_SEG];
  logic [7:0]       rep_tab_q  [NUM_SEG];
  logic             tab_we;

  logic [SEG_W-1:0] seg_q, seg_d;
  logic [SEG_W-1:0] seg_inc;
  logic [SEG_W-1:0] last_seg_q, last_seg_d;
  logic             loop_q, loop_d;
  logic [7:0]       rep_cnt_q, rep_cnt_d;
  logic             core_en_q, core_en_d;
  logic [7:0]       sync_cnt_q, sync_cnt_d;
  logic [15:0]      sub_cnt_q, sub_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wr_err_q, wr_err_d;

  // The table is frozen while running so the core never sees a half-updated segment.
  assign tab_we  = wr_if.wr_en_i && (state_q == S_IDLE);
  assign seg_inc = seg_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SEG; i++) begin
        sync_tab_q[i] <= '0;
        sub_tab_q[i]  <= '0;
        rep_tab_q[i]  <= '0;
      end
    end else if (tab_we) begin
      sync_tab_q[wr_if.wr_addr_i] <= wr_if.wr_sync_cnt_i;
      sub_tab_q[wr_if.wr_addr_i]  <= wr_if.wr_subcycle_cnt_i;
      rep_tab_q[wr_if.wr_addr_i]  <= wr_if.wr_repeat_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    seg_d      = seg_q;
    last_seg_d = last_seg_q;
    loop_d     = loop_q;
    rep_cnt_d  = rep_cnt_q;
    core_en_d  = core_en_q;
    sync_cnt_d = sync_cnt_q;
    sub_cnt_d  = sub_cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    wr_err_d   = wr_if.wr_en_i && (state_q == S_RUN);

    case (state_q)
      S_IDLE: begin
        if (start_i && !stop_i) begin
          state_d    = S_RUN;
          seg_d      = SEG_ZERO;
          last_seg_d = cfg_last_seg_i;
          loop_d     = cfg_loop_i;
          rep_cnt_d  = '0;
          core_en_d  = 1'b1;
          busy_d     = 1'b1;
          sync_cnt_d = sync_tab_q[SEG_ZERO];
          sub_cnt_d  = sub_tab_q[SEG_ZERO];
        end
      end
      S_RUN: begin
        if (stop_i) begin
          state_d   = S_IDLE;
          rep_cnt_d = '0;
          core_en_d = 1'b0;
          busy_d    = 1'b0;
        end else if (wfg_pat_sync_i) begin
          if (rep_cnt_q == rep_tab_q[seg_q]) begin
            rep_cnt_d = '0;
            if (seg_q == last_seg_q) begin
              if (loop_q) begin
                seg_d      = SEG_ZERO;
                sync_cnt_d = sync_tab_q[SEG_ZERO];
                sub_cnt_d  = sub_tab_q[SEG_ZERO];
              end else begin
                // Index and thresholds stay on the final segment for software to read back.
                state_d   = S_IDLE;
                core_en_d = 1'b0;
                busy_d    = 1'b0;
                done_d    = 1'b1;
              end
            end else begin
              seg_d      = seg_inc;
              sync_cnt_d = sync_tab_q[seg_inc];
              sub_cnt_d  = sub_tab_q[seg_inc];
            end
          end else begin
            rep_cnt_d = rep_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      seg_q      <= '0;
      last_seg_q <= '0;
      loop_q     <= 1'b0;
      rep_cnt_q  <= '0;
      core_en_q  <= 1'b0;
      sync_cnt_q <= '0;
      sub_cnt_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      seg_q      <= seg_d;
      last_seg_q <= last_seg_d;
      loop_q     <= loop_d;
      rep_cnt_q  <= rep_cnt_d;
      core_en_q  <= core_en_d;
      sync_cnt_q <= sync_cnt_d;
      sub_cnt_q  <= sub_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_err_q   <= wr_err_d;
    end
  end

  assign core_en_o             = core_en_q;
  assign core_sync_count_o     = sync_cnt_q;
  assign core_subcycle_count_o = sub_cnt_q;
  assign seg_idx_o             = seg_q;
  assign busy_o                = busy_q;
  assign done_o                = done_q;
  assign wr_if.wr_err_o        = wr_err_q;
endmodule

// File: tb/tb_wfg_seq_ctrl.sv
// tb/tb_wfg_seq_ctrl.sv - directed bench for the waveform segment sequencer
module tb_wfg_seq_ctrl;
  localparam int NUM_SEG = 4;

  logic       clk;
  logic       rst_n;
  logic [1:0] cfg_last_seg;
  logic       cfg_loop;
  logic       start;
  logic       stop;
  logic       pat_sync;
  logic       core_en;
  logic [7:0] core_sync;
  logic [15:0] core_sub;
  logic [1:0] seg_idx;
  logic       busy;
  logic       done;

  int n_chk;
  int n_pass;

  wfg_seq_ctrl_if #(.NUM_SEG(NUM_SEG)) wr_if ();

  wfg_seq_ctrl #(.NUM_SEG(NUM_SEG)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .wr_if                 (wr_if.slave),
    .cfg_last_seg_i        (cfg_last_seg),
    .cfg_loop_i            (cfg_loop),
    .start_i               (start),
    .stop_i                (stop),
    .wfg_pat_sync_i        (pat_sync),
    .core_en_o             (core_en),
    .core_sync_count_o     (core_sync),
    .core_subcycle_count_o (core_sub),
    .seg_idx_o             (seg_idx),
    .busy_o                (busy),
    .done_o                (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v)
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    else
      n_pass++;
  endtask

  // Advance one clock; inputs and checks happen 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [1:0] a, input logic [7:0] s,
                             input logic [15:0] sub, input logic [7:0] rep);
    wr_if.wr_en_i           = 1'b1;
    wr_if.wr_addr_i         = a;
    wr_if.wr_sync_cnt_i     = s;
    wr_if.wr_subcycle_cnt_i = sub;
    wr_if.wr_repeat_i       = rep;
    step();
    wr_if.wr_en_i = 1'b0;
  endtask

  task automatic start_run(input logic [1:0] last, input logic lp);
    cfg_last_seg = last;
    cfg_loop     = lp;
    start        = 1'b1;
    step();
    start        = 1'b0;
  endtask

  task automatic sync_pulse();
    pat_sync = 1'b1;
    step();
    pat_sync = 1'b0;
  endtask

  task automatic stop_run();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  logic [1:0] loop_exp [6];

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    cfg_last_seg = '0;
    cfg_loop = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    pat_sync = 1'b0;
    wr_if.wr_en_i = 1'b0;
    wr_if.wr_addr_i = '0;
    wr_if.wr_sync_cnt_i = '0;
    wr_if.wr_subcycle_cnt_i = '0;
    wr_if.wr_repeat_i = '0;
    loop_exp[0] = 2'd0; loop_exp[1] = 2'd0; loop_exp[2] = 2'd1;
    loop_exp[3] = 2'd0; loop_exp[4] = 2'd0; loop_exp[5] = 2'd1;

    step();
    step();
    chk("rst_core_en", 32'(core_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_seg", 32'(seg_idx), 32'd0);
    chk("rst_sync", 32'(core_sync), 32'd0);
    chk("rst_sub", 32'(core_sub), 32'd0);
    rst_n = 1'b1;
    step();

    write_entry(2'd0, 8'd2, 16'd10, 8'd1);
    chk("wr_idle_no_err", 32'(wr_if.wr_err_o), 32'd0);
    write_entry(2'd1, 8'd3, 16'd20, 8'd0);

    // One-shot: seg0 for 2 syncs, seg1 for 1 sync, then done.
    start_run(2'd1, 1'b0);
    chk("os_core_en", 32'(core_en), 32'd1);
    chk("os_busy", 32'(busy), 32'd1);
    chk("os_seg0", 32'(seg_idx), 32'd0);
    chk("os_sync0", 32'(core_sync), 32'd2);
    chk("os_sub0", 32'(core_sub), 32'd10);
    sync_pulse();
    chk("os_seg_after1", 32'(seg_idx), 32'd0);
    chk("os_done_after1", 32'(done), 32'd0);
    sync_pulse();
    chk("os_seg_after2", 32'(seg_idx), 32'd1);
    chk("os_sync1", 32'(core_sync), 32'd3);
    chk("os_sub1", 32'(core_sub), 32'd20);
    chk("os_en_after2", 32'(core_en), 32'd1);
    sync_pulse();
    chk("os_en_end", 32'(core_en), 32'd0);
    chk("os_busy_end", 32'(busy), 32'd0);
    chk("os_done_end", 32'(done), 32'd1);
    chk("os_seg_hold", 32'(seg_idx), 32'd1);
    chk("os_sync_hold", 32'(core_sync), 32'd3);
    step();
    chk("os_done_pulse", 32'(done), 32'd0);

    // Loop: segment sequence 0,0,1,0,0,1 and no done.
    start_run(2'd1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("loop_seg%0d", i), 32'(seg_idx), 32'(loop_exp[i]));
      sync_pulse();
      chk($sformatf("loop_done%0d", i), 32'(done), 32'd0);
      chk($sformatf("loop_busy%0d", i), 32'(busy), 32'd1);
    end
    chk("loop_wrap_seg", 32'(seg_idx), 32'd0);
    stop_run();
    chk("loop_stop_en", 32'(core_en), 32'd0);
    chk("loop_stop_busy", 32'(busy), 32'd0);
    chk("loop_stop_done", 32'(done), 32'd0);

    // Write while busy is dropped and flagged.
    start_run(2'd1, 1'b1);
    write_entry(2'd0, 8'd9, 16'd99, 8'd7);
    chk("wrb_err", 32'(wr_if.wr_err_o), 32'd1);
    step();
    chk("wrb_err_pulse", 32'(wr_if.wr_err_o), 32'd0);
    stop_run();
    start_run(2'd0, 1'b0);
    chk("wrb_sync_kept", 32'(core_sync), 32'd2);
    chk("wrb_sub_kept", 32'(core_sub), 32'd10);
    sync_pulse();
    chk("wrb_rep_kept", 32'(busy), 32'd1);
    stop_run();

    // start+stop in IDLE stays idle; stop in IDLE is harmless.
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    chk("col_ss_busy", 32'(busy), 32'd0);
    chk("col_ss_en", 32'(core_en), 32'd0);
    stop_run();
    chk("col_idle_stop", 32'(busy), 32'd0);

    // stop on the final sync wins over completion.
    start_run(2'd1, 1'b0);
    sync_pulse();
    sync_pulse();
    chk("col_fs_seg1", 32'(seg_idx), 32'd1);
    pat_sync = 1'b1;
    stop = 1'b1;
    step();
    pat_sync = 1'b0;
    stop = 1'b0;
    chk("col_fs_busy", 32'(busy), 32'd0);
    chk("col_fs_en", 32'(core_en), 32'd0);
    chk("col_fs_done", 32'(done), 32'd0);
    step();
    chk("col_fs_done2", 32'(done), 32'd0);

    // Repeat 255 means 256 sync periods.
    write_entry(2'd0, 8'd5, 16'd7, 8'd255);
    start_run(2'd0, 1'b0);
    for (int i = 1; i <= 255; i++) begin
      sync_pulse();
      chk($sformatf("rep_done_%0d", i), 32'(done), 32'd0);
      chk($sformatf("rep_busy_%0d", i), 32'(busy), 32'd1);
    end
    sync_pulse();
    chk("rep_done_256", 32'(done), 32'd1);
    chk("rep_busy_256", 32'(busy), 32'd0);

    // Reset mid-run clears outputs at once and wipes the table.
    write_entry(2'd0, 8'd4, 16'd44, 8'd0);
    start_run(2'd0, 1'b1);
    chk("mr_pre_sync", 32'(core_sync), 32'd4);
    rst_n = 1'b0;
    #2;
    chk("mr_en", 32'(core_en), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_seg", 32'(seg_idx), 32'd0);
    chk("mr_sync", 32'(core_sync), 32'd0);
    chk("mr_sub", 32'(core_sub), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    start_run(2'd0, 1'b0);
    chk("mr_tab_sync", 32'(core_sync), 32'd0);
    chk("mr_tab_sub", 32'(core_sub), 32'd0);
    chk("mr_run_en", 32'(core_en), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
